// File: rtl/capture_pkg.sv
// Shared types, constants and helpers for the capture sequencer (capture_ctrl and cap_decim).
package capture_pkg;

    typedef enum logic [2:0] {IDLE, FILL, ARMED, POST, DONE} cap_state_t;

    localparam int DEC_CNT_W = 16;

    // Post-trigger count is capped so at least one pre-trigger sample always fits.
    function automatic int unsigned pe_clamp(input int unsigned trig_pos, input int unsigned depth);
        return (trig_pos > depth - 1) ? depth - 1 : trig_pos;
    endfunction

endpackage

// File: rtl/cap_decim.sv
// Decimation counter: strobe fires once every 2^decimator enabled clocks.
module cap_decim
    import capture_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       clr,
    input  logic [3:0] decimator,
    output logic       strobe
);

    logic [DEC_CNT_W-1:0] r_cnt;
    logic [DEC_CNT_W-1:0] w_last;

    assign w_last = (DEC_CNT_W'(1) << decimator) - DEC_CNT_W'(1);
    assign strobe = en && (r_cnt == w_last);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= strobe ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/capture_ctrl.sv
// Multi-channel capture sequencer feeding circular RAM queues through one shared write port.
// Define CAPTURE_TRIG_ADDR_EN to add the trig_addr output (address of the trigger sample).
module capture_ctrl
    import capture_pkg::*;
#(
    parameter int NCH   = 5,
    parameter int DW    = 8,
    parameter int DEPTH = 384,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              trig,
    input  logic [3:0]        decimator,
    input  logic [AW-1:0]     trig_pos,
    input  logic [NCH*DW-1:0] ch_in,
    output logic              we,
    output logic [AW-1:0]     waddr,
    output logic [NCH*DW-1:0] wdata,
    output logic              capturing,
    output logic              set_capture_done
`ifdef CAPTURE_TRIG_ADDR_EN
    ,
    output logic [AW-1:0]     trig_addr
`endif
);

    cap_state_t        r_state;
    logic              r_we;
    logic [AW-1:0]     r_wptr;
    logic [NCH*DW-1:0] r_wdata;
    logic              r_capturing;
    logic              r_done;
    logic              r_done_arm;
    logic [3:0]        r_dec;
    logic [AW-1:0]     r_pe;
    logic [AW:0]       r_fill_cnt;
    logic [AW:0]       r_post_cnt;

    logic              w_strobe;
    logic              w_start_ok;
    logic [AW:0]       w_fill_tgt;
    logic [AW:0]       w_pe_ext;
    logic [AW-1:0]     w_wptr_inc;
    logic [AW-1:0]     w_wptr_next;

    assign w_start_ok  = start && (r_state == IDLE || r_state == DONE);
    assign w_pe_ext    = {1'b0, r_pe};
    assign w_fill_tgt  = (AW+1)'(DEPTH) - w_pe_ext;
    assign w_wptr_inc  = (r_wptr == AW'(DEPTH - 1)) ? '0 : r_wptr + 1'b1;
    // The pointer steps past each slot once its write cycle has gone out.
    assign w_wptr_next = r_we ? w_wptr_inc : r_wptr;

    cap_decim u_decim (
        .clk       (clk),
        .rst       (rst),
        .en        (r_capturing),
        .clr       (w_start_ok),
        .decimator (r_dec),
        .strobe    (w_strobe)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_we        <= 1'b0;
            r_wptr      <= '0;
            r_wdata     <= '0;
            r_capturing <= 1'b0;
            r_done      <= 1'b0;
            r_done_arm  <= 1'b0;
            r_dec       <= '0;
            r_pe        <= '0;
            r_fill_cnt  <= '0;
            r_post_cnt  <= '0;
        end else begin
            r_we       <= w_strobe;
            r_wptr     <= w_wptr_next;
            r_done     <= r_done_arm;
            r_done_arm <= 1'b0;
            if (w_strobe) begin
                r_wdata <= ch_in;
            end
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_state     <= FILL;
                        r_capturing <= 1'b1;
                        r_fill_cnt  <= '0;
                        r_post_cnt  <= '0;
                        r_dec       <= decimator;
                        r_pe        <= AW'(pe_clamp(32'(trig_pos), 32'(DEPTH)));
                    end
                end
                FILL: begin
                    if (w_strobe) begin
                        r_fill_cnt <= r_fill_cnt + 1'b1;
                        if (r_fill_cnt + 1'b1 == w_fill_tgt) begin
                            r_state <= ARMED;
                        end
                    end
                end
                ARMED: begin
                    if (w_strobe && trig) begin
                        r_post_cnt <= '0;
                        if (r_pe == '0) begin
                            r_state     <= DONE;
                            r_capturing <= 1'b0;
                            r_done_arm  <= 1'b1;
                        end else begin
                            r_state <= POST;
                        end
                    end
                end
                POST: begin
                    if (w_strobe) begin
                        r_post_cnt <= r_post_cnt + 1'b1;
                        if (r_post_cnt + 1'b1 == w_pe_ext) begin
                            r_state     <= DONE;
                            r_capturing <= 1'b0;
                            r_done_arm  <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_capturing <= 1'b0;
                end
            endcase
        end
    end

`ifdef CAPTURE_TRIG_ADDR_EN
    logic [AW-1:0] r_trig_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_trig_addr <= '0;
        end else if (r_state == ARMED && w_strobe && trig) begin
            r_trig_addr <= w_wptr_next;
        end
    end

    assign trig_addr = r_trig_addr;
`endif

    assign we               = r_we;
    assign waddr            = r_wptr;
    assign wdata            = r_wdata;
    assign capturing        = r_capturing;
    assign set_capture_done = r_done;

endmodule
